// File: rtl/tlc_param_programmer.sv
// tlc_param_programmer: shadow-buffered timing parameter writer for the traffic controller.
// Host edits collect in a shadow file; a commit replays dirty entries as framed reprogram strobes.
module tlc_param_programmer #(
    parameter int SEL_W     = 2,
    parameter int VAL_W     = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int WAIT_SAFE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [VAL_W-1:0]      cfg_value,
    input  logic                  commit,
    input  logic                  safe_window,
    output logic                  busy,
    output logic                  done,
    output logic [2**SEL_W-1:0]   pending,
    output logic [SEL_W-1:0]      time_param_selector,
    output logic [VAL_W-1:0]      time_value,
    output logic                  reprogram
);
    localparam int NUM = 2**SEL_W;
    localparam logic [7:0] SL = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HL = 8'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, WAITS, SETUP, STROBE, HOLD, DONE} state_t;

    state_t               state_q, state_d;
    logic [VAL_W-1:0]     shadow_q [NUM];
    logic [VAL_W-1:0]     shadow_d [NUM];
    logic [NUM-1:0]       pend_q, pend_d;
    logic [SEL_W-1:0]     sel_q, sel_d, k;
    logic [VAL_W-1:0]     val_q, val_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 rep_q, rep_d, busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;

    function automatic logic [SEL_W-1:0] lowest(input logic [NUM-1:0] p);
        lowest = '0;
        for (int i = NUM - 1; i >= 0; i--)
            if (p[i]) lowest = SEL_W'(i);
    endfunction

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        sel_d    = sel_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        k        = '0;
        // cfg_ready is only high in IDLE, so a same-cycle write lands before the commit looks at pending
        if (cfg_valid && rdy_q) begin
            shadow_d[cfg_sel] = cfg_value;
            pend_d[cfg_sel]   = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (commit) begin
                    k = lowest(pend_d);
                    if (pend_d == '0) begin
                        state_d = DONE;
                    end else if (WAIT_SAFE != 0) begin
                        state_d = WAITS;
                    end else begin
                        state_d = SETUP;
                        sel_d   = k;
                        val_d   = shadow_d[k];
                        cnt_d   = '0;
                    end
                end
            end
            WAITS: begin
                if (safe_window) begin
                    k       = lowest(pend_q);
                    state_d = SETUP;
                    sel_d   = k;
                    val_d   = shadow_q[k];
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == SL) state_d = STROBE;
                else cnt_d = cnt_q + 8'd1;
            end
            STROBE: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (cnt_q == HL) begin
                    pend_d[sel_q] = 1'b0;
                    k = lowest(pend_d);
                    if (pend_d != '0) begin
                        state_d = SETUP;
                        sel_d   = k;
                        val_d   = shadow_q[k];
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rep_d  = state_d == STROBE;
        busy_d = state_d == WAITS || state_d == SETUP || state_d == STROBE || state_d == HOLD;
        done_d = state_d == DONE;
        rdy_d  = state_d == IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '{default: '0};
            pend_q   <= '0;
            sel_q    <= '0;
            val_q    <= '0;
            cnt_q    <= '0;
            rep_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
        end
    end

    // Masking with reset keeps a strobe from escaping in the very cycle reset is raised
    assign reprogram           = rep_q & ~reset;
    assign cfg_ready           = rdy_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign pending             = pend_q;
    assign time_param_selector = sel_q;
    assign time_value          = val_q;
endmodule

// File: tb/tb_tlc_param_programmer.sv
// tb_tlc_param_programmer: scoreboard bench; u0 runs without the safe gate, u1 with it.
module tb_tlc_param_programmer;
    typedef struct {int s; int v;} ent_t;

    logic clock = 0, reset = 1, cfg_valid = 0, commit = 0, safe_window = 1;
    logic [1:0] cfg_sel = 0;
    logic [3:0] cfg_value = 0;
    logic rdy [2], busy [2], done [2], rep [2];
    logic [3:0] pend [2], pval [2];
    logic [1:0] psel [2];

    int n_cmp = 0, n_bad = 0, cyc = 0, c0 = 0, n0 = 0, idx0 = 0;
    bit exp_done [2] = '{0, 0};
    int shadow_m [4];
    bit pend_m [4];
    ent_t q0 [$], q1 [$];
    ent_t me;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tlc_param_programmer #(.WAIT_SAFE(0)) u0 (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]),
        .cfg_sel(cfg_sel), .cfg_value(cfg_value), .commit(commit), .safe_window(safe_window),
        .busy(busy[0]), .done(done[0]), .pending(pend[0]), .time_param_selector(psel[0]),
        .time_value(pval[0]), .reprogram(rep[0]));
    tlc_param_programmer #(.WAIT_SAFE(1)) u1 (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]),
        .cfg_sel(cfg_sel), .cfg_value(cfg_value), .commit(commit), .safe_window(safe_window),
        .busy(busy[1]), .done(done[1]), .pending(pend[1]), .time_param_selector(psel[1]),
        .time_value(pval[1]), .reprogram(rep[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pm();
        int r = 0;
        for (int i = 0; i < 4; i++) if (pend_m[i]) r |= (1 << i);
        return r;
    endfunction

    // Monitor: every strobe must match the head of that instance's expected queue
    always @(negedge clock) begin
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                if (rep[u]) begin
                    if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("u%0d_spurious_strobe", u), int'(rep[u]), 0);
                    end else begin
                        if (u == 0) me = q0.pop_front(); else me = q1.pop_front();
                        chk($sformatf("u%0d_strobe_sel", u), int'(psel[u]), me.s);
                        chk($sformatf("u%0d_strobe_val", u), int'(pval[u]), me.v);
                        if (u == 0) begin
                            chk("u0_strobe_time", cyc - c0 + 1, 2 + 3 * idx0);
                            idx0++;
                        end
                    end
                end
                if (done[u]) begin
                    chk($sformatf("u%0d_spurious_done", u), int'(done[u]), int'(exp_done[u]));
                    chk($sformatf("u%0d_done_leftover", u), (u == 0 ? q0.size() : q1.size()), 0);
                    chk($sformatf("u%0d_done_busy", u), int'(busy[u]), 0);
                    if (u == 0) chk("u0_done_time", cyc - c0 + 1, 3 * n0 + 1);
                    exp_done[u] = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int s, input int v);
        cfg_valid = 1; cfg_sel = 2'(s); cfg_value = 4'(v);
        step();
        cfg_valid = 0;
        shadow_m[s] = v;
        pend_m[s] = 1;
        chk("pending_after_write", int'(pend[0]), pm());
    endtask

    task automatic do_commit(input bit with_wr, input int s, input int v);
        commit = 1;
        if (with_wr) begin
            cfg_valid = 1; cfg_sel = 2'(s); cfg_value = 4'(v);
            shadow_m[s] = v;
            pend_m[s] = 1;
        end
        n0 = 0; idx0 = 0;
        for (int i = 0; i < 4; i++) begin
            if (pend_m[i]) begin
                q0.push_back('{i, shadow_m[i]});
                q1.push_back('{i, shadow_m[i]});
                n0++;
            end
            pend_m[i] = 0;
        end
        exp_done = '{1, 1};
        step();
        c0 = cyc;
        commit = 0; cfg_valid = 0;
    endtask

    task automatic wait_idle(input bit rnd_safe);
        for (int i = 0; i < 300; i++) begin
            if (rdy[0] && rdy[1]) break;
            safe_window = rnd_safe ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        safe_window = 1;
        chk("idle_reached", int'(rdy[0] && rdy[1]), 1);
        chk("u0_pending_idle", int'(pend[0]), pm());
        chk("u1_pending_idle", int'(pend[1]), pm());
        chk("u0_q_empty", q0.size(), 0);
        chk("u1_q_empty", q1.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_u%0d_ready", tag, u), int'(rdy[u]), 0);
            chk($sformatf("%s_u%0d_busy", tag, u), int'(busy[u]), 0);
            chk($sformatf("%s_u%0d_done", tag, u), int'(done[u]), 0);
            chk($sformatf("%s_u%0d_pending", tag, u), int'(pend[u]), 0);
            chk($sformatf("%s_u%0d_sel", tag, u), int'(psel[u]), 0);
            chk($sformatf("%s_u%0d_val", tag, u), int'(pval[u]), 0);
            chk($sformatf("%s_u%0d_rep", tag, u), int'(rep[u]), 0);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin shadow_m[i] = 0; pend_m[i] = 0; end
        q0.delete(); q1.delete();
        exp_done = '{0, 0};
    endtask

    initial begin
        model_clear();
        repeat (3) step();
        check_zero("por");
        reset = 0;
        step();
        chk("por_ready0", int'(rdy[0]), 1);
        chk("por_ready1", int'(rdy[1]), 1);

        // T1: reset raised while u0 is strobing
        wr(1, 7);
        do_commit(0, 0, 0);
        step();
        reset = 1;
        #1;
        chk("t1_rep_in_reset_cycle", int'(rep[0]), 0);
        repeat (3) step();
        check_zero("t1");
        reset = 0;
        model_clear();
        step();
        chk("t1_ready_after0", int'(rdy[0]), 1);
        chk("t1_ready_after1", int'(rdy[1]), 1);
        chk("t1_pending_after", int'(pend[0]), 0);

        // T2: single edit, selector/value framed before the strobe
        wr(2, 6);
        do_commit(0, 0, 0);
        chk("t2_sel_cyc1", int'(psel[0]), 2);
        chk("t2_val_cyc1", int'(pval[0]), 6);
        chk("t2_rep_cyc1", int'(rep[0]), 0);
        chk("t2_busy_cyc1", int'(busy[0]), 1);
        wait_idle(0);

        // T3: overwrite and ascending replay order
        wr(3, 9); wr(0, 4); wr(3, 5);
        do_commit(0, 0, 0);
        wait_idle(0);

        // T4: safe window gate on u1
        wr(1, 3);
        safe_window = 0;
        do_commit(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t4_u1_busy", int'(busy[1]), 1);
            chk("t4_u1_no_rep", int'(rep[1]), 0);
            step();
        end
        safe_window = 1;
        step();
        chk("t4_u1_setup_no_rep", int'(rep[1]), 0);
        step();
        chk("t4_u1_strobe", int'(rep[1]), 1);
        wait_idle(0);

        // T5: empty commit
        do_commit(0, 0, 0);
        chk("t5_done0", int'(done[0]), 1);
        chk("t5_done1", int'(done[1]), 1);
        wait_idle(0);

        // T6: writes and commits ignored while busy
        wr(0, 2);
        do_commit(0, 0, 0);
        cfg_valid = 1; cfg_sel = 2'd1; cfg_value = 4'd15; commit = 1;
        step();
        chk("t6_ready0", int'(rdy[0]), 0);
        chk("t6_ready1", int'(rdy[1]), 0);
        step();
        cfg_valid = 0; commit = 0;
        wait_idle(0);
        repeat (8) step();
        chk("t6_pending_still0", int'(pend[0]), 0);
        chk("t6_no_second_busy", int'(busy[0] | busy[1]), 0);

        // Randomized edit/commit rounds, including same-cycle write+commit
        for (int r = 0; r < 30; r++) begin
            int nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) wr($urandom_range(0, 3), $urandom_range(0, 15));
            do_commit(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15));
            wait_idle(1);
        end

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
